// File: rtl/ahb_pkg.sv
// Shared AHB bridge definitions: slave FSM states, HSIZE/HTRANS codes and byte-lane decode.
package ahb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StDone,
    StErr1,
    StErr2
  } ahb_state_e;

  localparam logic [2:0] HsizeByte = 3'd0;
  localparam logic [2:0] HsizeHalf = 3'd1;
  localparam logic [2:0] HsizeWord = 3'd2;

  localparam logic HtransActive = 1'b1;

  // Little-endian byte-lane enables for a transfer of the given size at addr_lo.
  function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (hsize)
      HsizeByte: mask = 4'b0001 << addr_lo;
      HsizeHalf: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      HsizeWord: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/sram_bytewr.sv
// Word-wide storage with per-byte write enables and asynchronous read. Contents are never reset.
module sram_bytewr #(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];

  // Byte-lane writes; untouched lanes keep their old value.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, two-cycle ERROR response, byte-lane writes
// committed at the end of the DONE cycle.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,  // only 32 supported
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256, // power of 2, at least 2
  parameter int unsigned WAIT_STATES = 1    // 0..15
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_hselx,
  input  logic                  i_hready,
  input  logic                  i_htrans,
  input  logic [2:0]            i_hsize,
  input  logic                  i_hwrite,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);

  localparam int unsigned IdxW        = $clog2(MEM_DEPTH);
  localparam int unsigned LoW         = IdxW + 2;
  localparam int unsigned WaitLoadInt = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WaitLoad    = 4'(WaitLoadInt);

  ahb_state_e     state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           hwrite_q;
  logic [2:0]     hsize_q;
  logic [LoW-1:0] haddr_q;
  logic           err_q;

  logic           addr_oob;
  logic           xfer_err;
  logic           ready_state;
  logic           accept;
  logic [3:0]     sram_we;
  logic [31:0]    sram_rdata;

  // Any address bit at or above the memory span means out of range.
  if (ADDR_WIDTH > LoW) begin : g_oob
    assign addr_oob = |i_haddr[ADDR_WIDTH-1:LoW];
  end else begin : g_no_oob
    assign addr_oob = 1'b0;
  end

  assign xfer_err = addr_oob
                  | (i_hsize > HsizeWord)
                  | ((i_hsize == HsizeHalf) & i_haddr[0])
                  | ((i_hsize == HsizeWord) & (|i_haddr[1:0]));

  // ERR2 behaves like IDLE/DONE: the slave is ready and may take a new address phase.
  assign ready_state = (state_q == StIdle) | (state_q == StDone) | (state_q == StErr2);
  assign accept      = i_hselx & (i_htrans == HtransActive) & i_hready & ready_state;

  // State and wait counter registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address-phase capture on every accepted transfer.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hwrite_q <= 1'b0;
      hsize_q  <= 3'd0;
      haddr_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      hwrite_q <= i_hwrite;
      hsize_q  <= i_hsize;
      haddr_q  <= i_haddr[LoW-1:0];
      err_q    <= xfer_err;
    end
  end

  // Next-state, wait counter and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_hreadyout = 1'b1;
    o_hresp     = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr2: begin
        o_hresp = (state_q == StErr2);
        if (accept) begin
          if (xfer_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StDone;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        o_hreadyout = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: begin
        o_hreadyout = 1'b0;
        o_hresp     = 1'b1;
        state_d     = StErr2;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write data is valid in the DONE cycle, so the commit happens on its closing edge.
  always_comb begin
    sram_we = 4'b0000;
    if ((state_q == StDone) && hwrite_q && !err_q) begin
      sram_we = lane_mask(hsize_q, haddr_q[1:0]);
    end
  end

  // Read data is driven only while a read occupies its data phase.
  always_comb begin
    o_hrdata = '0;
    if (((state_q == StWait) || (state_q == StDone)) && !hwrite_q) begin
      o_hrdata = sram_rdata;
    end
  end

  sram_bytewr #(
    .Depth (MEM_DEPTH),
    .AddrW (IdxW)
  ) u_sram (
    .clk_i   (i_clk),
    .we_i    (sram_we),
    .addr_i  (haddr_q[LoW-1:2]),
    .wdata_i (i_hwdata),
    .rdata_o (sram_rdata)
  );

endmodule
